// File: rtl/jtag_tx_queue.sv
// Transmit mailbox for the JTAG POP path: first-word-fall-through FIFO whose head is
// presented as {valid, payload}. Each POP capture consumes exactly one word.
module jtag_tx_queue #(
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 31,
  parameter int DROP_W    = 8
) (
  input  logic                       tck,
  input  logic                       reset,
  input  logic [PAYLOAD_W-1:0]       wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       pop_capture,
  output logic [PAYLOAD_W:0]         out_word,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]     LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_wr;
  logic                 do_pop;
  logic                 do_drop;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_ONE;
  endfunction

  // All decisions come from registered state plus this cycle's strobes; outputs never see the strobes.
  assign wr_ready = (level != LVL_FULL);
  assign do_wr    = wr_valid && wr_ready;
  assign do_drop  = wr_valid && !wr_ready;
  assign do_pop   = pop_capture && (level != '0);
  assign out_word = (level != '0) ? {1'b1, mem[rd_ptr]} : '0;

  always_ff @(posedge tck) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      // drop_cnt is deliberately held across a flush; only reset clears it
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (do_drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; level gates visibility so stale words are never presented.
  always_ff @(posedge tck) begin
    if (!reset && !flush && do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_jtag_tx_queue.sv
// Scoreboard bench for jtag_tx_queue: accepted writes are queued as expected host words
// and popped when a POP capture is driven.
module tb_jtag_tx_queue;
  localparam int DEPTH = 16;
  localparam int PW    = 31;
  localparam int DW    = 8;
  localparam int LW    = 5;

  logic          tck = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          pop_capture = 1'b0;
  logic [31:0]   out_word;
  logic          flush = 1'b0;
  logic [LW-1:0] level;
  logic [DW-1:0] drop_cnt;
  logic          overflow;

  logic [31:0]   sb[$];
  logic [DW-1:0] m_drop = '0;
  logic          m_ovf = 1'b0;
  logic [31:0]   got;
  logic [31:0]   exp;
  int            n_chk = 0;
  int            n_pass = 0;

  jtag_tx_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .DROP_W(DW)) dut (
    .tck(tck), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .pop_capture(pop_capture), .out_word(out_word), .flush(flush), .level(level),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 tck = ~tck;

  // Drive one cycle; capture pre-edge out_word and the scoreboard's expected host word.
  task automatic step(input logic rs, input logic wv, input logic [PW-1:0] wd,
                      input logic pc, input logic fl);
    logic full;
    reset = rs; wr_valid = wv; wr_data = wd; pop_capture = pc; flush = fl;
    @(negedge tck);
    got  = out_word;
    exp  = 32'h0;
    full = (sb.size() == DEPTH);
    if (rs) begin
      sb.delete(); m_drop = '0; m_ovf = 1'b0;
    end else if (fl) begin
      sb.delete(); m_ovf = 1'b0;
    end else begin
      if (pc && sb.size() != 0) exp = sb.pop_front();
      if (wv) begin
        if (!full) sb.push_back({1'b1, wd});
        else begin
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge tck); #1;
    reset = 1'b0; wr_valid = 1'b0; pop_capture = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    n_chk++; if (level !== 5'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", wr_ready); else n_pass++;
    n_chk++; if (out_word !== 32'h0) $display("FAIL reset_out_word got %h want 0", out_word); else n_pass++;
    n_chk++; if (drop_cnt !== 8'h0) $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_chk++; if (got !== 32'h0) $display("FAIL empty_pop got %h want 0", got); else n_pass++;
    n_chk++; if (level !== 5'd0 || wr_ready !== 1'b1)
      $display("FAIL empty_pop_state got level %0d ready %b want 0 1", level, wr_ready); else n_pass++;
  endtask

  task automatic test_single();
    step(1'b0, 1'b1, 31'h1234567, 1'b0, 1'b0);
    n_chk++; if (level !== 5'd1) $display("FAIL single_level got %0d want 1", level); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_chk++; if (got !== 32'h81234567) $display("FAIL single_pop got %h want 81234567", got); else n_pass++;
    n_chk++; if (got !== exp) $display("FAIL single_sb got %h want %h", got, exp); else n_pass++;
    n_chk++; if (out_word !== 32'h0 || level !== 5'd0)
      $display("FAIL single_after got %h/%0d want 0/0", out_word, level); else n_pass++;
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, PW'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 31'h7FFFFFFF, 1'b0, 1'b0);
    n_chk++; if (wr_ready !== 1'b0 || level !== 5'd16)
      $display("FAIL full_state got ready %b level %0d want 0 16", wr_ready, level); else n_pass++;
    n_chk++; if (drop_cnt !== 8'd1 || overflow !== 1'b1)
      $display("FAIL first_drop got cnt %0d ovf %b want 1 1", drop_cnt, overflow); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      n_chk++; if (got !== {1'b1, PW'(i)} || got !== exp)
        $display("FAIL drain_%0d got %h want %h", i, got, {1'b1, PW'(i)}); else n_pass++;
    end
    n_chk++; if (level !== 5'd0 || out_word !== 32'h0)
      $display("FAIL drained got level %0d word %h want 0 0", level, out_word); else n_pass++;
  endtask

  task automatic test_full_pop_write();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, PW'(32'h100 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 31'h0AAA, 1'b1, 1'b0);
    n_chk++; if (got !== 32'h80000100 || got !== exp)
      $display("FAIL fullpw_pop got %h want 80000100", got); else n_pass++;
    n_chk++; if (level !== 5'd15 || wr_ready !== 1'b1 || drop_cnt !== 8'd2)
      $display("FAIL fullpw_state got level %0d ready %b cnt %0d want 15 1 2", level, wr_ready, drop_cnt); else n_pass++;
    step(1'b0, 1'b1, 31'h0BBB, 1'b0, 1'b0);
    n_chk++; if (level !== 5'd16) $display("FAIL fullpw_refill got %0d want 16", level); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      n_chk++; if (got !== exp) $display("FAIL fullpw_drain_%0d got %h want %h", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_empty_wr_pop();
    step(1'b0, 1'b1, 31'h55, 1'b1, 1'b0);
    n_chk++; if (got !== 32'h0) $display("FAIL emptywp_pop got %h want 0", got); else n_pass++;
    n_chk++; if (level !== 5'd1) $display("FAIL emptywp_level got %0d want 1", level); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_chk++; if (got !== 32'h80000055 || got !== exp)
      $display("FAIL emptywp_next got %h want 80000055", got); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PW'(32'h200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, PW'(32'h300 + i), 1'b1, 1'b0);
      n_chk++; if (got !== exp || level !== 5'd3)
        $display("FAIL b2b_%0d got %h/%0d want %h/3", i, got, level, exp); else n_pass++;
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PW'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 31'h77, 1'b1, 1'b1);
    n_chk++; if (level !== 5'd0 || out_word !== 32'h0 || overflow !== 1'b0)
      $display("FAIL flush_state got %0d %h %b want 0 0 0", level, out_word, overflow); else n_pass++;
    n_chk++; if (drop_cnt !== m_drop || drop_cnt !== 8'd2)
      $display("FAIL flush_drop_held got %0d want 2", drop_cnt); else n_pass++;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PW'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 31'h66, 1'b0, 1'b0);
    n_chk++; if (level !== 5'd0 || out_word !== 32'h0 || drop_cnt !== 8'd0 || wr_ready !== 1'b1)
      $display("FAIL midreset got %0d %h %0d %b want 0 0 0 1", level, out_word, drop_cnt, wr_ready); else n_pass++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, PW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 31'h1, 1'b0, 1'b0);
    n_chk++; if (drop_cnt !== 8'hFF || drop_cnt !== m_drop)
      $display("FAIL sat_drop got %h want ff", drop_cnt); else n_pass++;
    n_chk++; if (overflow !== 1'b1 || level !== 5'd16)
      $display("FAIL sat_state got %b %0d want 1 16", overflow, level); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_chk++; if (drop_cnt !== 8'hFF || overflow !== 1'b0 || level !== 5'd0)
      $display("FAIL sat_flush got %h %b %0d want ff 0 0", drop_cnt, overflow, level); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_full_pop_write();
    test_empty_wr_pop();
    test_back_to_back();
    test_flush_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
